// File: rtl/s1_dmx_loader_if.sv
// s1_dmx_loader_if: groups the control, data and handshake signals of the
// S1 demux loader.
//   master : the driving side. It drives clr, din, load, auto, a1, b1, a0,
//            en0 and out_rdy, and it observes q, q_valid, fill and overrun.
//   slave  : the loader itself. It is the mirror image of master.
interface s1_dmx_loader_if #(
  parameter int WIDTH = 1
);
  logic               clr;
  logic [WIDTH-1:0]   din;
  logic               load;
  logic               auto;
  logic               a1;
  logic               b1;
  logic               a0;
  logic               en0;
  logic               out_rdy;
  logic [4*WIDTH-1:0] q;
  logic               q_valid;
  logic [3:0]         fill;
  logic               overrun;

  modport master (
    output clr, din, load, auto, a1, b1, a0, en0, out_rdy,
    input  q, q_valid, fill, overrun
  );

  modport slave (
    input  clr, din, load, auto, a1, b1, a0, en0, out_rdy,
    output q, q_valid, fill, overrun
  );
endinterface

// File: rtl/s1_dmx_loader.sv
// s1_dmx_loader: the inverse of the S1 cell. It scatters din into one of four
// registered slots. Once all four slots hold data, it offers the assembled
// frame downstream with a valid/ready handshake.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of s1_dmx_loader_if
//           inputs  : clr, din, load, auto, a1/b1/a0/en0, out_rdy
//           outputs : q (slot i at q[i*WIDTH +: WIDTH]), q_valid, fill,
//                     overrun
// Every output comes straight from a flop.
module s1_dmx_loader #(
  parameter int WIDTH = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  s1_dmx_loader_if.slave    bus
);
  typedef enum logic {S_FILL = 1'b0, S_FULL = 1'b1} state_t;

  state_t                r_state;
  logic [3:0][WIDTH-1:0] r_q;
  logic [3:0]            r_fill;
  logic                  r_valid;
  logic                  r_ovr;
  logic [1:0]            r_ptr;

  logic [1:0]            w_idx;
  logic [3:0]            w_onehot;

  // The slot-select gates match the S1 mux select: bit1 = a1|b1, bit0 = a0&en0.
  assign w_idx    = bus.auto ? r_ptr : {bus.a1 | bus.b1, bus.a0 & bus.en0};
  assign w_onehot = 4'b0001 << w_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_FILL;
      r_q     <= '0;
      r_fill  <= '0;
      r_valid <= 1'b0;
      r_ovr   <= 1'b0;
      r_ptr   <= '0;
    end else if (bus.clr) begin
      r_state <= S_FILL;
      r_q     <= '0;
      r_fill  <= '0;
      r_valid <= 1'b0;
      r_ovr   <= 1'b0;
      r_ptr   <= '0;
    end else begin
      case (r_state)
        S_FILL: begin
          if (bus.load) begin
            r_q[w_idx] <= bus.din;
            r_fill     <= r_fill | w_onehot;
            if (bus.auto) r_ptr <= r_ptr + 2'd1;
            if ((r_fill | w_onehot) == 4'hF) begin
              r_state <= S_FULL;
              r_valid <= 1'b1;
            end
          end
        end
        S_FULL: begin
          if (bus.out_rdy) begin
            // The frame has been taken. A load in the same cycle starts the
            // next frame. One slot can never complete a frame, so the block
            // always lands back in FILL.
            r_state <= S_FILL;
            r_valid <= 1'b0;
            if (bus.load) begin
              r_q[w_idx] <= bus.din;
              r_fill     <= w_onehot;
              if (bus.auto) r_ptr <= r_ptr + 2'd1;
            end else begin
              r_fill <= '0;
            end
          end else if (bus.load) begin
            r_ovr <= 1'b1;  // dropped load; sticky until clr or reset
          end
        end
        default: r_state <= S_FILL;
      endcase
    end
  end

  assign bus.q       = r_q;
  assign bus.fill    = r_fill;
  assign bus.q_valid = r_valid;
  assign bus.overrun = r_ovr;
endmodule

// File: tb/tb_s1_dmx_loader.sv
module tb_s1_dmx_loader;
  localparam int W = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  s1_dmx_loader_if #(.WIDTH(W)) bus();
  s1_dmx_loader #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    logic [4*W-1:0] q;
    logic [3:0]     fill;
    logic           v;
    logic           o;
  } exp_t;

  exp_t sbq[$];
  int   n_pass = 0;
  int   n_tot  = 0;

  // Reference model: four slots, a written flag per slot, a "frame offered"
  // flag, a sticky overrun flag and an auto pointer.
  logic [W-1:0] m_slot[4];
  bit           m_wr[4];
  bit           m_full;
  bit           m_ovr;
  int           m_ptr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act !== exp) $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  function automatic void m_reset();
    for (int i = 0; i < 4; i++) begin m_slot[i] = '0; m_wr[i] = 0; end
    m_full = 0; m_ovr = 0; m_ptr = 0;
  endfunction

  function automatic exp_t m_snap();
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      e.q[i*W +: W] = m_slot[i];
      e.fill[i]     = m_wr[i];
    end
    e.v = m_full;
    e.o = m_ovr;
    return e;
  endfunction

  function automatic void m_apply();
    int  idx;
    bit  all;
    if (bus.clr) begin m_reset(); return; end
    idx = bus.auto ? m_ptr : (((bus.a1 || bus.b1) ? 2 : 0) + ((bus.a0 && bus.en0) ? 1 : 0));
    if (m_full && !bus.out_rdy) begin
      if (bus.load) m_ovr = 1;
      return;
    end
    if (m_full) begin  // handshake completes: start an empty frame
      m_full = 0;
      for (int i = 0; i < 4; i++) m_wr[i] = 0;
    end else if (!bus.load) return;
    if (bus.load) begin
      m_slot[idx] = bus.din;
      m_wr[idx]   = 1;
      if (bus.auto) m_ptr = (m_ptr + 1) % 4;
      all = m_wr[0] && m_wr[1] && m_wr[2] && m_wr[3];
      if (all) m_full = 1;
    end
  endfunction

  // The caller has already driven the inputs. Predict the result, then move
  // past the edge.
  task automatic step();
    m_apply();
    sbq.push_back(m_snap());
    @(posedge clk); #1;
  endtask

  task automatic drv(input logic ld, au, a1_, b1_, a0_, en0_, input logic [W-1:0] dn,
                     input logic rdy, cl);
    bus.load = ld; bus.auto = au; bus.a1 = a1_; bus.b1 = b1_; bus.a0 = a0_;
    bus.en0 = en0_; bus.din = dn; bus.out_rdy = rdy; bus.clr = cl;
    step();
  endtask

  // Monitor: compares every post-edge output against the oldest prediction.
  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      exp_t e;
      e = sbq.pop_front();
      chk("q",       32'(bus.q),       32'(e.q));
      chk("fill",    32'(bus.fill),    32'(e.fill));
      chk("q_valid", 32'(bus.q_valid), 32'(e.v));
      chk("overrun", 32'(bus.overrun), 32'(e.o));
    end
  end

  initial begin
    m_reset();
    bus.clr = 0; bus.din = '0; bus.load = 0; bus.auto = 0; bus.a1 = 0; bus.b1 = 0;
    bus.a0 = 0; bus.en0 = 0; bus.out_rdy = 0;
    #12;
    chk("rst_q",    32'(bus.q), 0);
    chk("rst_fill", 32'(bus.fill), 0);
    chk("rst_v",    32'(bus.q_valid), 0);
    chk("rst_ovr",  32'(bus.overrun), 0);
    rst_n = 1;

    // Gate-indexed fill of slots 0..3 with din 1,0,1,1.
    drv(1, 0, 0, 0, 0, 0, 1, 0, 0);
    drv(1, 0, 0, 0, 1, 1, 0, 0, 0);
    drv(1, 0, 1, 0, 0, 0, 1, 0, 0);
    drv(1, 0, 0, 1, 1, 1, 1, 0, 0);
    chk("gate_q",    32'(bus.q), 32'hD);
    chk("gate_fill", 32'(bus.fill), 32'hF);
    chk("gate_v",    32'(bus.q_valid), 1);

    // Drain the frame. Then a0=1 with en0=0 must land in slot 0, and the
    // slot is rewritten twice.
    drv(0, 0, 0, 0, 0, 0, 0, 1, 0);
    drv(1, 0, 0, 0, 1, 0, 1, 0, 0);
    chk("gating_fill", 32'(bus.fill), 32'h1);
    drv(1, 0, 0, 0, 1, 0, 1, 0, 0);
    drv(1, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("rewrite_q0",   32'(bus.q[0]), 0);
    chk("rewrite_fill", 32'(bus.fill), 32'h1);

    // Write slot 2 so that fill = 0101, then assert the async reset mid-frame.
    drv(1, 0, 1, 0, 0, 0, 1, 0, 0);
    chk("pre_rst_fill", 32'(bus.fill), 32'h5);
    @(negedge clk); #1;
    rst_n = 0; #1;
    chk("async_q",    32'(bus.q), 0);
    chk("async_fill", 32'(bus.fill), 0);
    chk("async_v",    32'(bus.q_valid), 0);
    m_reset();
    @(negedge clk); #1;
    rst_n = 1; #1;
    chk("post_rst_fill", 32'(bus.fill), 0);
    chk("post_rst_v",    32'(bus.q_valid), 0);

    // Auto mode: five loads. The fifth arrives while FULL and is dropped.
    drv(1, 1, 0, 0, 0, 0, 1, 0, 0);
    drv(1, 1, 0, 0, 0, 0, 0, 0, 0);
    drv(1, 1, 0, 0, 0, 0, 0, 0, 0);
    drv(1, 1, 0, 0, 0, 0, 1, 0, 0);
    chk("auto_q", 32'(bus.q), 32'h9);
    chk("auto_v", 32'(bus.q_valid), 1);
    drv(1, 1, 0, 0, 0, 0, 1, 0, 0);
    chk("ovr_set", 32'(bus.overrun), 1);
    chk("ovr_q",   32'(bus.q), 32'h9);

    // Handshake and load together. The pointer was still 0, so the load
    // lands in slot 0. The next auto load then proves that the pointer is 1.
    drv(1, 1, 0, 0, 0, 0, 1, 1, 0);
    chk("hs_v",    32'(bus.q_valid), 0);
    chk("hs_fill", 32'(bus.fill), 32'h1);
    chk("hs_q0",   32'(bus.q[0]), 1);
    drv(1, 1, 0, 0, 0, 0, 1, 0, 0);
    chk("ptr1_fill", 32'(bus.fill), 32'h3);

    // Complete the frame, then assert clr together with load and out_rdy.
    drv(1, 1, 0, 0, 0, 0, 0, 0, 0);
    drv(1, 1, 0, 0, 0, 0, 1, 0, 0);
    chk("full2_v", 32'(bus.q_valid), 1);
    drv(1, 1, 0, 0, 0, 0, 1, 1, 1);
    chk("clr_q",    32'(bus.q), 0);
    chk("clr_fill", 32'(bus.fill), 0);
    chk("clr_v",    32'(bus.q_valid), 0);
    chk("clr_ovr",  32'(bus.overrun), 0);
    drv(1, 1, 0, 0, 0, 0, 1, 0, 0);
    chk("clr_ptr0", 32'(bus.fill), 32'h1);

    // Randomized traffic, checked only through the scoreboard.
    for (int n = 0; n < 400; n++) begin
      drv(logic'($urandom_range(0, 1)), logic'($urandom_range(0, 1)),
          logic'($urandom_range(0, 1)), logic'($urandom_range(0, 1)),
          logic'($urandom_range(0, 1)), logic'($urandom_range(0, 1)),
          W'($urandom), logic'($urandom_range(0, 3) == 0),
          logic'($urandom_range(0, 39) == 0));
    end
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0);

    for (int k = 0; k < 10 && sbq.size() > 0; k++) @(negedge clk);
    #2;
    if (sbq.size() > 0) chk("drain", 32'(sbq.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule

// File: doc/s1_dmx_loader.md
Name: s1_dmx_loader

Overview:
- Inverse of the S1 logic cell. S1 selects one of four data inputs into a single flop; this block distributes one data input into one of four registered slots.
- Slot select uses the same gate structure as S1: bit1 = a1 OR b1, bit0 = a0 AND en0. An auto-index mode is also provided.
- Once all four slots are written, the block presents the frame with a valid/ready handshake to the downstream S1/C1 logic.

Parameters:
- WIDTH, 1, bits per slot; din and each q slot are WIDTH wide.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- clr  input  1  synchronous clear; highest priority after rst_n
- din  input  WIDTH  data to write
- load  input  1  write strobe
- auto  input  1  1 = slot from internal pointer; 0 = slot from gates
- a1, b1  input  1  slot bit1 = a1|b1
- a0, en0  input  1  slot bit0 = a0&en0
- out_rdy  input  1  downstream accepts frame
- q  output  4*WIDTH  slot i at q[i*WIDTH +: WIDTH]
- q_valid  output  1  frame complete, held until accepted
- fill  output  4  per-slot written mask
- overrun  output  1  sticky; a load arrived while FULL

Behaviour:
- Reset (rst_n=0, async):
  - q=0, fill=0, q_valid=0, overrun=0, ptr=0, state=FILL.
- Synchronous clear (clr=1 at a clk edge):
  - Same values as reset.
  - Overrides load and handshake in that cycle.
- Slot index:
  - auto=0: idx = {a1|b1, a0&en0}, sampled in the load cycle.
  - auto=1: idx = ptr (2-bit).
    - ptr increments modulo 4 on every accepted load, wrapping 3->0.
    - ptr does not change on dropped loads or when auto=0.
- State FILL (q_valid=0):
  - load=1 writes din into slot idx and sets fill[idx]; visible on q and fill the next cycle.
  - Rewriting an already-filled slot replaces its data; fill is unchanged.
  - The edge that makes fill==4'b1111 moves state to FULL; q_valid=1 from the following cycle.
- State FULL (q_valid=1):
  - q and fill are frozen.
  - load without out_rdy is dropped and sets overrun=1.
  - out_rdy=1 completes the handshake: state returns to FILL and fill clears to 0; q keeps its stale data (don't-care).
- Handshake and load in the same FULL cycle:
  - The load is accepted into the new frame: next fill = one-hot(idx), slot idx = din, overrun unchanged.
  - In auto mode ptr advances.
- out_rdy while in FILL is ignored.
- overrun clears only on clr or reset.
- Mid-frame reset (rst_n low at any time) discards the partial frame immediately, without waiting for a clk edge.
- No combinational path from inputs to outputs; every output is registered.

Test Plan:
- Reset/apply: drive rst_n=0 mid-frame with fill=4'b0101 -> outputs go to 0 without a clk edge; after rst_n=1, fill=0 and q_valid=0.
- Gate-index fill, WIDTH=1, auto=0, din=1,0,1,1 to (a1,b1,a0,en0) = (0,0,0,0), (0,0,1,1), (1,0,0,0), (0,1,1,1) -> q=4'b1101, fill=4'b1111, q_valid=1 one cycle after the 4th load.
- Gating check: a0=1, en0=0, a1=0 -> write lands in slot 0, not slot 1. Then rewrite slot 0 twice (din 1 then 0) -> q[0]=0, fill=4'b0001.
- Auto mode, ptr wrap: 5 loads with din=1,0,0,1,1 -> after 4 loads q=4'b1001 and q_valid=1. The 5th load, issued while FULL with out_rdy=0, is dropped: overrun=1, q=4'b1001 unchanged, ptr stays 0.
- Simultaneous handshake and load: in FULL, out_rdy=1 and load=1 with din=1, auto=1, ptr=0 -> next cycle q_valid=0, fill=4'b0001, q[0]=1, ptr=1.
- Clear priority: while FULL, assert clr=1 with load=1 and out_rdy=1 -> next cycle q=0, fill=0, q_valid=0, overrun=0, ptr=0.
